uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
- Parametrised UART receiver for the cipher datapath: serial line in, one parallel word per frame out.
- Configurable data width, parity mode, stop-bit count and baud divisor.
- Adds a valid/ready output handshake plus parity, framing and overrun status.
- Sits between the board RX pin and the cipher input stage.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits per second.
- OVERSAMPLE, 16, ticks per bit cell; must be 16.
- DATA_BITS, 8, payload width; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits checked; 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clk edge).
- rxd_data_in  in  1  asynchronous serial line; idles high.
- rx_data  out  DATA_BITS  received word, LSB received first.
- rx_valid  out  1  rx_data and its flags are valid.
- rx_ready  in  1  consumer accepts the word.
- parity_err  out  1  parity mismatch for the held word.
- frame_err  out  1  a stop bit sampled low for the held word.
- overrun  out  1  sticky: a frame was dropped because the held word was not accepted.

Behaviour:
- Reset: every output 0; internal line sync flops 1; tick counter 0; state IDLE.
- Reset mid-frame: the frame is abandoned and produces no output.
- Input synchronisation: 2-FF synchroniser on rxd_data_in. All decisions use the synchronised value.
- Tick generator:
  - DIV = CLK_HZ/(BAUD*OVERSAMPLE), integer truncation (651 at defaults).
  - Counter runs 0..DIV-1; tick is a one-clk pulse at DIV-1, free-running.
- Phase counter: 4 bits, cleared to 0 on the tick where the start edge is detected, then incremented every tick with wrap 15->0.
- Sample point: value at phase 8. The bit index advances on the tick with phase==15.
- States (transitions evaluated on tick only):
  - IDLE: synced line==0 -> START, phase<=0.
  - START: at phase 8, sample==1 (glitch) -> IDLE; otherwise continue. At phase 15 -> DATA, bit_idx<=0.
  - DATA: sample shifts into bit bit_idx. At phase 15, if bit_idx==DATA_BITS-1 go to PARITY (PARITY!=0) or STOP; else bit_idx++.
  - PARITY: sample compared with XOR of data bits. Odd mode expects XOR of data^parity==1; even mode expects 0. Result latched as perr. At phase 15 -> STOP.
  - STOP: each of STOP_BITS samples; any 0 latches ferr. After the final stop phase 8 sample -> DELIVER (no wait for phase 15).
  - DELIVER: one clk, not tick-gated.
    - If rx_valid==0, or (rx_valid && rx_ready) in this same clk: load rx_data, parity_err, frame_err, and set rx_valid.
    - Else: drop the frame, set overrun, keep the held word.
    - Go to WAIT_HIGH if ferr, else IDLE.
  - WAIT_HIGH: stay until synced line==1 on a tick, then IDLE. This suppresses retriggering during a break.
- Handshake:
  - rx_valid stays high until a clk with rx_valid&&rx_ready, then drops next clk unless a DELIVER coincides.
  - rx_data is stable while rx_valid==1.
  - overrun clears on the accept handshake.
- Latency: rx_valid rises 2 clk after the tick sampling the last stop bit.
- Unused bits: PARITY==0 forces parity_err=0.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: each sample is the 2-of-3 majority of the synced line at phases 7, 8, 9, applied to start, data, parity and stop. Decisions made at phase 8 move to phase 9.
- Undefined: single sample at phase 8, as above.
- Ports are identical in both builds.

Decomposition:
- Package uart_pkg:
  - parity constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - state encoding localparams (IDLE, START, DATA, PARITY, STOP, DELIVER, WAIT_HIGH);
  - a constant function computing DIV and its counter width via $clog2.
- Sub-module uart_baud_tick (CLK_HZ, BAUD, OVERSAMPLE -> tick), reusable by the transmitter.

Test Plan:
- Bench parameters unless stated: CLK_HZ=1600000, BAUD=100000, so DIV=1 and a bit cell is 16 clk.
- 8N1, send 0xA5, rx_ready=1 -> rx_data=0xA5, rx_valid high 1 clk, parity_err=0, frame_err=0.
- Line low for 4 ticks then high -> no rx_valid, FSM back in IDLE; a following 0x3C is received correctly.
- PARITY=2, send 0x03 with parity bit 1 -> rx_data=0x03, parity_err=1. Same frame with parity 0 -> parity_err=0.
- Line held low 20 bit times (break) -> one word 0x00 with frame_err=1, then no further rx_valid until the line returns high; next 0x55 received clean.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun=1. Pulse rx_ready -> rx_valid and overrun drop. rst=0 asserted mid-frame of 0x77 -> no output, all outputs 0.
- Send 0xFF with a 1-clk low glitch at phase 8 of bit 3 -> 0xFF with UART_RX_MAJORITY_EN defined, 0xF7 without.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path (and the matching transmitter):
//   - parity mode constants PAR_NONE / PAR_ODD / PAR_EVEN
//   - receiver state encoding (ST_* localparams and the state_t enum)
//   - constant functions for the oversample tick divisor and its counter width
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_DELIVER   = 3'd5;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_START     = ST_START,
        S_DATA      = ST_DATA,
        S_PARITY    = ST_PARITY,
        S_STOP      = ST_STOP,
        S_DELIVER   = ST_DELIVER,
        S_WAIT_HIGH = ST_WAIT_HIGH
    } state_t;

    // Clocks per oversample tick, truncated toward zero.
    function automatic int baud_div(input int clk_hz, input int baud, input int oversample);
        return clk_hz / (baud * oversample);
    endfunction

    // Width of a counter that spans 0..div-1; never narrower than one bit.
    function automatic int baud_cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running oversample tick generator shared by the UART receiver and
// transmitter. A counter runs 0..DIV-1 with DIV = CLK_HZ/(BAUD*OVERSAMPLE);
// tick is high for the one clk in which the counter holds DIV-1.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous reset, active-low
//   tick  out  one-clk oversample strobe
// -----------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            DIV      = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int            CW       = baud_cnt_width(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // With DIV == 1 the counter is pinned at 0 and tick is high every clk.
    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver: serial line in, one DATA_BITS word per frame out
// through a valid/ready handshake, with parity, framing and overrun status.
//
// Build option: define UART_RX_MAJORITY_EN to take every bit decision from a
// 2-of-3 vote of the synchronised line at phases 7, 8 and 9 (decision made at
// phase 9). Without it a single sample at phase 8 is used. Ports are identical.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active-low
//   rxd_data_in  in   asynchronous serial line, idles high
//   rx_data      out  received word, LSB received first (stable while valid)
//   rx_valid     out  rx_data and its flags are valid
//   rx_ready     in   consumer accepts the word
//   parity_err   out  parity mismatch for the held word (0 when PARITY == 0)
//   frame_err    out  a stop bit sampled low for the held word
//   overrun      out  sticky: a frame was dropped while a word was held;
//                     cleared by the accept handshake
// -----------------------------------------------------------------------------
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd_data_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int               IDX_W      = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);
    localparam logic             ODD_MODE   = (PARITY == PAR_ODD);
    localparam logic             HAS_PARITY = (PARITY != PAR_NONE);
    localparam logic             STOP_LAST  = (STOP_BITS == 2);
    localparam logic [3:0]       PHASE_END  = 4'd15;
`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0]       PHASE_DECIDE = 4'd9;
`else
    localparam logic [3:0]       PHASE_DECIDE = 4'd8;
`endif

    logic                 tick;
    logic                 line_meta;
    logic                 line;
    logic                 sample;
    state_t               state;
    logic [3:0]           phase;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;
    logic                 ferr;

    uart_baud_tick #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Two-flop synchroniser; both flops reset to the idle (high) level so a
    // reset never looks like a start edge.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, exactly like the hardware.
    always_ff @(posedge clk) begin
        if (!rst) begin
            line_meta <= 1'b1;
            line      <= 1'b1;
        end else begin
            line_meta <= rxd_data_in;
            line      <= line_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic s7;
    logic s8;

    // Capture the phase-7 and phase-8 samples; the vote completes at phase 9
    // with the live synchronised line as the third voter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s7 <= 1'b1;
            s8 <= 1'b1;
        end else if (tick) begin
            if (phase == 4'd7) s7 <= line;
            if (phase == 4'd8) s8 <= line;
        end
    end

    assign sample = (s7 & s8) | (s7 & line) | (s8 & line);
`else
    assign sample = line;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            phase      <= 4'd0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            shreg      <= '0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
            // NOTE: the data word is reset along with the control flops so the
            // outputs read all-zero out of reset rather than stale or X data.
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Accept handshake. DELIVER below assigns later in this block, so
            // a coinciding delivery wins and rx_valid stays high.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (tick && !line) begin
                        state    <= S_START;
                        phase    <= 4'd0;
                        stop_cnt <= 1'b0;
                        perr     <= 1'b0;
                        ferr     <= 1'b0;
                    end
                end

                S_START: begin
                    if (tick) begin
                        phase <= phase + 4'd1;
                        // A start bit that reads high at mid-cell was a glitch.
                        if (phase == PHASE_DECIDE && sample) begin
                            state <= S_IDLE;
                        end else if (phase == PHASE_END) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end
                    end
                end

                S_DATA: begin
                    if (tick) begin
                        phase <= phase + 4'd1;
                        if (phase == PHASE_DECIDE) begin
                            shreg[bit_idx] <= sample;
                        end
                        if (phase == PHASE_END) begin
                            if (bit_idx == IDX_LAST) begin
                                state <= HAS_PARITY ? S_PARITY : S_STOP;
                            end else begin
                                bit_idx <= bit_idx + IDX_W'(1);
                            end
                        end
                    end
                end

                S_PARITY: begin
                    if (tick) begin
                        phase <= phase + 4'd1;
                        // Odd mode wants an odd count of ones over data+parity.
                        if (phase == PHASE_DECIDE) begin
                            perr <= (^{shreg, sample}) ^ ODD_MODE;
                        end
                        if (phase == PHASE_END) begin
                            state <= S_STOP;
                        end
                    end
                end

                S_STOP: begin
                    if (tick) begin
                        phase <= phase + 4'd1;
                        if (phase == PHASE_DECIDE) begin
                            if (!sample) ferr <= 1'b1;
                            // Deliver straight after the last stop sample so
                            // the next start edge can be caught on time.
                            if (stop_cnt == STOP_LAST) state <= S_DELIVER;
                        end
                        if (phase == PHASE_END) begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end

                S_DELIVER: begin
                    if (!rx_valid || rx_ready) begin
                        rx_data    <= shreg;
                        parity_err <= HAS_PARITY & perr;
                        frame_err  <= ferr;
                        rx_valid   <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                    // After a framing error the line may be in a break; wait
                    // for it to return high before hunting for a start edge.
                    state <= ferr ? S_WAIT_HIGH : S_IDLE;
                end

                S_WAIT_HIGH: begin
                    if (tick && line) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
// Two receivers at one tick per clk (16 clk per bit cell): u_n is 8N1 and u_p
// is 8 data bits, even parity, two stop bits. Expected words come from a
// frame-level model: each cell's value as seen at its sampling instant, with a
// one-clk low glitch either captured (single sample) or voted away (majority).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 100000;
    localparam int CELL   = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam bit         MAJ       = 1'b1;
    localparam logic [7:0] GLITCH_FF = 8'hFF;
`else
    localparam bit         MAJ       = 1'b0;
    localparam logic [7:0] GLITCH_FF = 8'hF7;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic [7:0] run;
    } word_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxd_n = 1'b1, rxd_p = 1'b1;
    logic       rdy_n = 1'b1, rdy_p = 1'b1;
    logic [7:0] data_n, data_p;
    logic       val_n, val_p, pe_n, pe_p, fe_n, fe_p, ov_n, ov_p;

    int    checks = 0;
    int    failures = 0;
    int    nacc_n = 0, nacc_p = 0;
    int    run_n = 0, run_p = 0;
    word_t got_n[$];
    word_t got_p[$];

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) u_n (
        .clk(clk), .rst(rst), .rxd_data_in(rxd_n),
        .rx_data(data_n), .rx_valid(val_n), .rx_ready(rdy_n),
        .parity_err(pe_n), .frame_err(fe_n), .overrun(ov_n)
    );

    uart_rx_param #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16),
        .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)
    ) u_p (
        .clk(clk), .rst(rst), .rxd_data_in(rxd_p),
        .rx_data(data_p), .rx_valid(val_p), .rx_ready(rdy_p),
        .parity_err(pe_p), .frame_err(fe_p), .overrun(ov_p)
    );

    // Handshake monitor, sampled mid-cycle. run = clks rx_valid was high up
    // to and including the accepting clk.
    always @(negedge clk) begin
        run_n <= val_n ? run_n + 1 : 0;
        run_p <= val_p ? run_p + 1 : 0;
        if (val_n && rdy_n) begin
            got_n.push_back(word_t'{data_n, pe_n, fe_n, 8'(run_n + 1)});
            nacc_n <= nacc_n + 1;
        end
        if (val_p && rdy_p) begin
            got_p.push_back(word_t'{data_p, pe_p, fe_p, 8'(run_p + 1)});
            nacc_p <= nacc_p + 1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=time_limit required=summary_reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ncells(input bit inst);
        return inst ? 12 : 10;
    endfunction

    // Line level for cell c: start, 8 data bits LSB first, [parity], stop(s).
    function automatic logic cell_val(input bit inst, input logic [7:0] d, input logic pb,
                                      input logic [1:0] st, input int c);
        if (c == 0) return 1'b0;
        if (c <= 8) return d[3'(c - 1)];
        if (inst) begin
            if (c == 9)  return pb;
            if (c == 10) return st[0];
            return st[1];
        end
        return st[0];
    endfunction

    // The receiver sees each cell 9 clk after it starts (2 sync flops, one
    // clk to detect the start edge, then 8 phases at one tick per clk). A
    // single low clk there is captured by a lone sample and outvoted by a
    // 2-of-3 vote.
    function automatic logic seen(input bit inst, input logic [7:0] d, input logic pb,
                                  input logic [1:0] st, input int gl, input int c);
        if (!MAJ && gl == c * CELL + 9) return 1'b0;
        return cell_val(inst, d, pb, st, c);
    endfunction

    function automatic word_t model(input bit inst, input logic [7:0] d, input logic pb,
                                    input logic [1:0] st, input int gl);
        word_t w;
        for (int i = 0; i < 8; i++) w.d[i] = seen(inst, d, pb, st, gl, i + 1);
        w.run = 8'd1;
        if (inst) begin
            w.pe = ^{w.d, seen(inst, d, pb, st, gl, 9)};
            w.fe = !(seen(inst, d, pb, st, gl, 10) && seen(inst, d, pb, st, gl, 11));
        end else begin
            w.pe = 1'b0;
            w.fe = !seen(inst, d, pb, st, gl, 9);
        end
        return w;
    endfunction

    function automatic word_t mk(input logic [7:0] d, input logic pe, input logic fe);
        return word_t'{d, pe, fe, 8'd1};
    endfunction

    // One clk of line level; every step ends 1 time unit after a rising edge.
    task automatic cyc(input bit inst, input logic v);
        if (inst) rxd_p = v; else rxd_n = v;
        @(posedge clk); #1;
    endtask

    task automatic drive_frame(input bit inst, input logic [7:0] d, input logic pb,
                               input logic [1:0] st, input int gl, input int lim);
        for (int c = 0; c < ncells(inst) && c < lim; c++) begin
            for (int k = 0; k < CELL; k++) begin
                cyc(inst, (c * CELL + k == gl) ? 1'b0 : cell_val(inst, d, pb, st, c));
            end
        end
    endtask

    task automatic send(input bit inst, input logic [7:0] d, input logic pb,
                        input logic [1:0] st, input int gl);
        drive_frame(inst, d, pb, st, gl, 99);
        repeat (6) cyc(inst, 1'b1);
    endtask

    task automatic expect_word(input bit inst, input string tag, input word_t exp,
                               input bit chk_run);
        int    t;
        int    have;
        word_t w;
        t    = 0;
        have = inst ? got_p.size() : got_n.size();
        while (have == 0 && t < 400) begin
            @(posedge clk); #1;
            t++;
            have = inst ? got_p.size() : got_n.size();
        end
        check({tag, "/present"}, 32'(have != 0), 32'd1);
        if (have != 0) begin
            if (inst) w = got_p.pop_front(); else w = got_n.pop_front();
            check({tag, "/data"}, 32'(w.d), 32'(exp.d));
            check({tag, "/parity_err"}, 32'(w.pe), 32'(exp.pe));
            check({tag, "/frame_err"}, 32'(w.fe), 32'(exp.fe));
            if (chk_run) check({tag, "/valid_clks"}, 32'(w.run), 32'(exp.run));
        end
    endtask

    initial begin
        int         nb;
        logic [7:0] d;
        logic       pb;
        logic [1:0] st;
        int         gl;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset/rx_data", 32'(data_n), 32'd0);
        check("reset/rx_valid", 32'({val_n, val_p}), 32'd0);
        check("reset/flags", 32'({pe_n, fe_n, ov_n, pe_p, fe_p, ov_p}), 32'd0);
        rst = 1'b1;
        repeat (4) cyc(0, 1'b1);

        // Plain 8N1 word.
        send(0, 8'hA5, 1'b0, 2'b11, -1);
        expect_word(0, "8n1_a5", mk(8'hA5, 1'b0, 1'b0), 1'b1);

        // Four ticks low is a false start: nothing delivered.
        nb = nacc_n;
        repeat (4) cyc(0, 1'b0);
        repeat (40) cyc(0, 1'b1);
        check("false_start/no_word", 32'(nacc_n - nb), 32'd0);
        check("false_start/valid_low", 32'(val_n), 32'd0);
        send(0, 8'h3C, 1'b0, 2'b11, -1);
        expect_word(0, "after_false_start_3c", mk(8'h3C, 1'b0, 1'b0), 1'b1);

        // Even parity, two stop bits.
        send(1, 8'h03, 1'b1, 2'b11, -1);
        expect_word(1, "even_bad_parity", mk(8'h03, 1'b1, 1'b0), 1'b1);
        send(1, 8'h03, 1'b0, 2'b11, -1);
        expect_word(1, "even_good_parity", mk(8'h03, 1'b0, 1'b0), 1'b1);
        send(1, 8'h5A, 1'b0, 2'b01, -1);
        expect_word(1, "second_stop_low", mk(8'h5A, 1'b0, 1'b1), 1'b1);

        // Break: one framing-error word, then silence until the line is high.
        nb = nacc_n;
        repeat (20 * CELL) cyc(0, 1'b0);
        check("break/one_word", 32'(nacc_n - nb), 32'd1);
        expect_word(0, "break_word", mk(8'h00, 1'b0, 1'b1), 1'b1);
        repeat (20) cyc(0, 1'b1);
        check("break/quiet_after", 32'(nacc_n - nb), 32'd1);
        send(0, 8'h55, 1'b0, 2'b11, -1);
        expect_word(0, "after_break_55", mk(8'h55, 1'b0, 1'b0), 1'b1);

        // Overrun: consumer stalled, second frame dropped.
        rdy_n = 1'b0;
        send(0, 8'h11, 1'b0, 2'b11, -1);
        check("stall/valid", 32'(val_n), 32'd1);
        check("stall/data", 32'(data_n), 32'h11);
        check("stall/no_overrun", 32'(ov_n), 32'd0);
        send(0, 8'h22, 1'b0, 2'b11, -1);
        check("overrun/held_data", 32'(data_n), 32'h11);
        check("overrun/valid", 32'(val_n), 32'd1);
        check("overrun/flag", 32'(ov_n), 32'd1);
        rdy_n = 1'b1;
        @(posedge clk); #1;
        rdy_n = 1'b0;
        check("accept/valid_drops", 32'(val_n), 32'd0);
        check("accept/overrun_clears", 32'(ov_n), 32'd0);
        expect_word(0, "accepted_11", mk(8'h11, 1'b0, 1'b0), 1'b0);

        // Reset in the middle of a frame, with a word held.
        send(0, 8'h44, 1'b0, 2'b11, -1);
        check("held_44/data", 32'(data_n), 32'h44);
        drive_frame(0, 8'h77, 1'b0, 2'b11, -1, 5);
        rst   = 1'b0;
        rxd_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("midreset/rx_data", 32'(data_n), 32'd0);
        check("midreset/rx_valid", 32'(val_n), 32'd0);
        check("midreset/flags", 32'({pe_n, fe_n, ov_n}), 32'd0);
        check("midreset/other_data", 32'(data_p), 32'd0);
        rst   = 1'b1;
        rdy_n = 1'b1;
        nb    = nacc_n;
        repeat (200) cyc(0, 1'b1);
        check("midreset/no_word", 32'(nacc_n - nb), 32'd0);
        check("midreset/valid_low", 32'(val_n), 32'd0);

        // One-clk low glitch at the sampling instant of data bit 3.
        send(0, 8'hFF, 1'b0, 2'b11, 4 * CELL + 9);
        expect_word(0, "glitch_bit3", mk(GLITCH_FF, 1'b0, 1'b0), 1'b1);

        // Random frames against the model.
        for (int i = 0; i < 8; i++) begin
            d  = 8'($urandom);
            pb = 1'($urandom);
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            gl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(CELL, 9 * CELL - 1)) : -1;
            send(0, d, pb, st, gl);
            expect_word(0, "rand_8n1", model(0, d, pb, st, gl), 1'b1);

            d  = 8'($urandom);
            pb = 1'($urandom);
            st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            send(1, d, pb, st, -1);
            expect_word(1, "rand_8e2", model(1, d, pb, st, -1), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
